// File: rtl/wb_stage.sv
// wb_stage: RV32I write-back stage with load alignment and regfile write port.
// Optional WB_LOAD_TIMEOUT_EN adds a load-response timeout and load_timeout flag.
module wb_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chip_en,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_reg_write,
  input  logic        mem_is_load,
  input  logic [4:0]  mem_rd_addr,
  input  logic [2:0]  mem_funct3,
  input  logic [1:0]  mem_addr_lsb,
  input  logic [31:0] mem_alu_result,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        write_enable,
  output logic [4:0]  wr_port_add,
  output logic [31:0] wr_port_data,
  output logic        load_busy,
`ifdef WB_LOAD_TIMEOUT_EN
  output logic        load_timeout,
`endif
  output logic        err_unexp_rsp
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  logic [1:0]  state;
  logic [4:0]  rd_q;
  logic        rw_q;
  logic [2:0]  f3_q;
  logic [1:0]  lsb_q;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;
  logic        accept;
`ifdef WB_LOAD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt;
`endif
  assign mem_ready = chip_en && state != WAIT;
  assign accept = mem_valid && mem_ready;
  assign load_busy = state == WAIT;
  always_comb begin
    ld_b = dmem_rdata[8*lsb_q +: 8];
    ld_h = lsb_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data = f3_q == 3'b000 ? {{24{ld_b[7]}}, ld_b} :
              f3_q == 3'b100 ? {24'd0, ld_b} :
              f3_q == 3'b001 ? {{16{ld_h[15]}}, ld_h} :
              f3_q == 3'b101 ? {16'd0, ld_h} : dmem_rdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rd_q <= 5'd0;
      rw_q <= 1'b0;
      f3_q <= 3'd0;
      lsb_q <= 2'd0;
      write_enable <= 1'b0;
      wr_port_add <= 5'd0;
      wr_port_data <= 32'd0;
      err_unexp_rsp <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      cnt <= '0;
      load_timeout <= 1'b0;
`endif
    end else if (!chip_en) begin
      write_enable <= 1'b0;
    end else begin
      if (dmem_rvalid && state != WAIT) err_unexp_rsp <= 1'b1;
      if (accept) begin
        rd_q <= mem_rd_addr;
        rw_q <= mem_reg_write;
        f3_q <= mem_funct3;
        lsb_q <= mem_addr_lsb;
        if (mem_is_load) begin
          state <= WAIT;
          write_enable <= 1'b0;
        end else begin
          state <= WRITE;
          write_enable <= mem_reg_write && mem_rd_addr != 5'd0;
          wr_port_add <= mem_rd_addr;
          wr_port_data <= mem_alu_result;
        end
      end else if (state == WAIT && dmem_rvalid) begin
        state <= WRITE;
        write_enable <= rw_q && rd_q != 5'd0;
        wr_port_add <= rd_q;
        wr_port_data <= ld_data;
      end else if (state != WAIT) begin
        state <= IDLE;
        write_enable <= 1'b0;
      end
`ifdef WB_LOAD_TIMEOUT_EN
      if (accept && mem_is_load) cnt <= '0;
      else if (state == WAIT && !dmem_rvalid) begin
        cnt <= cnt + 1'b1;
        if (cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
          state <= IDLE;
          load_timeout <= 1'b1;
        end
      end
`endif
    end
  end
endmodule
